// File: rtl/wd_supervisor.sv
// Watchdog supervisor: arms/disarms a shared watchdog_timer, holds off monitoring for a
// grace period, and issues one heartbeat per round once every masked source has kicked.
module wd_supervisor #(
    parameter int NUM_SRC      = 4,
    parameter int GRACE_CYCLES = 1024,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               arm,
    input  logic               disarm,
    input  logic               clear,
    input  logic               force_req,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic [NUM_SRC-1:0] src_kick,
    input  logic               wd_warning,
    input  logic               wd_triggered,
    output logic               wd_enable,
    output logic               wd_heartbeat,
    output logic               wd_force_reset,
    output logic [1:0]         state,
    output logic [NUM_SRC-1:0] missing,
    output logic               fault,
    output logic [CNT_W-1:0]   round_cnt
);

    localparam int GW = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRACE = 2'd1,
        S_ARMED = 2'd2,
        S_TRIP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] miss_q, miss_d;
    logic [GW-1:0]      grace_q, grace_d;
    logic [CNT_W-1:0]   round_q, round_d;
    logic               en_q, en_d;
    logic               hb_q, hb_d;
    logic               fr_q, fr_d;
    logic               fault_q, fault_d;
    logic               warn_prev_q, force_prev_q;
    logic [NUM_SRC-1:0] nxt;
    logic               warn_rise, force_rise;

    assign nxt        = pend_q & ~(src_kick & mask_q);
    assign warn_rise  = wd_warning & ~warn_prev_q;
    assign force_rise = force_req & ~force_prev_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        miss_d  = miss_q;
        grace_d = grace_q;
        round_d = round_q;
        hb_d    = 1'b0;
        fr_d    = 1'b0;

        // Snapshot of who was still outstanding when the timer started warning.
        if (state_q == S_ARMED && warn_rise)
            miss_d = pend_q;

        case (state_q)
            S_IDLE: begin
                if (arm && !disarm && (src_mask != '0)) begin
                    state_d = S_GRACE;
                    mask_d  = src_mask;
                    grace_d = GW'(GRACE_CYCLES - 1);
                    round_d = '0;
                    hb_d    = 1'b1;
                end
            end
            S_GRACE, S_ARMED: begin
                if (wd_triggered) begin
                    state_d = S_TRIP;
                end else if (disarm) begin
                    state_d = S_IDLE;
                end else begin
                    fr_d = force_rise;
                    if (state_q == S_GRACE) begin
                        if (grace_q == '0) begin
                            state_d = S_ARMED;
                            pend_d  = mask_q;
                        end else begin
                            grace_d = grace_q - 1'b1;
                        end
                    end else if (nxt == '0) begin
                        pend_d = mask_q;
                        hb_d   = 1'b1;
                        if (round_q != '1)
                            round_d = round_q + 1'b1;
                    end else begin
                        pend_d = nxt;
                    end
                end
            end
            S_TRIP: begin
                if (clear)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE && state_q != S_IDLE) begin
            pend_d = '0;
            miss_d = '0;
        end

        en_d    = (state_d != S_IDLE);
        fault_d = (state_d == S_TRIP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            pend_q       <= '0;
            miss_q       <= '0;
            grace_q      <= '0;
            round_q      <= '0;
            en_q         <= 1'b0;
            hb_q         <= 1'b0;
            fr_q         <= 1'b0;
            fault_q      <= 1'b0;
            warn_prev_q  <= 1'b0;
            force_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            pend_q       <= pend_d;
            miss_q       <= miss_d;
            grace_q      <= grace_d;
            round_q      <= round_d;
            en_q         <= en_d;
            hb_q         <= hb_d;
            fr_q         <= fr_d;
            fault_q      <= fault_d;
            warn_prev_q  <= wd_warning;
            force_prev_q <= force_req;
        end
    end

    assign state          = state_q;
    assign wd_enable      = en_q;
    assign wd_heartbeat   = hb_q;
    assign wd_force_reset = fr_q;
    assign missing        = miss_q;
    assign fault          = fault_q;
    assign round_cnt      = round_q;

endmodule

// File: tb/tb_wd_supervisor.sv
// Scenario bench for wd_supervisor; heartbeat and force-reset pulses are matched
// against a scoreboard of expected (cycle, round) entries.
module tb_wd_supervisor;

    localparam int NUM_SRC = 4;
    localparam int GRACE   = 8;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               arm = 1'b0, disarm = 1'b0, clear = 1'b0, force_req = 1'b0;
    logic [NUM_SRC-1:0] src_mask = '0, src_kick = '0;
    logic               wd_warning = 1'b0, wd_triggered = 1'b0;
    logic               wd_enable, wd_heartbeat, wd_force_reset, fault;
    logic [1:0]         state;
    logic [NUM_SRC-1:0] missing;
    logic [CNT_W-1:0]   round_cnt;

    typedef struct {
        int cyc;
        int rnd;
    } hb_t;

    hb_t hb_q[$];
    int  fr_q[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;

    wd_supervisor #(.NUM_SRC(NUM_SRC), .GRACE_CYCLES(GRACE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .arm(arm), .disarm(disarm), .clear(clear),
        .force_req(force_req), .src_mask(src_mask), .src_kick(src_kick),
        .wd_warning(wd_warning), .wd_triggered(wd_triggered),
        .wd_enable(wd_enable), .wd_heartbeat(wd_heartbeat), .wd_force_reset(wd_force_reset),
        .state(state), .missing(missing), .fault(fault), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every pulse must match the oldest expected entry.
    always @(negedge clk) begin
        hb_t e;
        int  fc;
        if (wd_heartbeat === 1'b1) begin
            tests++;
            if (hb_q.size() == 0) begin
                fails++;
                $display("FAIL hb_unexpected at cyc %0d round_cnt %0d", cyc, round_cnt);
            end else begin
                e = hb_q.pop_front();
                if (cyc !== e.cyc || round_cnt !== CNT_W'(e.rnd)) begin
                    fails++;
                    $display("FAIL hb_match got cyc %0d round %0d exp cyc %0d round %0d",
                             cyc, round_cnt, e.cyc, e.rnd);
                end
            end
        end
        if (wd_force_reset === 1'b1) begin
            tests++;
            if (fr_q.size() == 0) begin
                fails++;
                $display("FAIL force_unexpected at cyc %0d", cyc);
            end else begin
                fc = fr_q.pop_front();
                if (cyc !== fc) begin
                    fails++;
                    $display("FAIL force_match got cyc %0d exp cyc %0d", cyc, fc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hb(input int r);
        hb_t e;
        e.cyc = cyc + 1;
        e.rnd = r;
        hb_q.push_back(e);
    endtask

    task automatic arm_to_armed(input logic [NUM_SRC-1:0] m);
        int n = 0;
        src_mask = m;
        arm = 1'b1;
        push_hb(0);
        tick();
        arm = 1'b0;
        while (state !== 2'd2 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (state !== 2'd2) begin
            fails++;
            $display("FAIL arm_wait got state %0d exp 2", state);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests++;
        if ({state, wd_enable, wd_heartbeat, wd_force_reset, missing, fault, round_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_vals got state %0d en %b cnt %0d exp all 0", state, wd_enable, round_cnt);
        end
        rstn = 1'b1;
        tick();
        tests++;
        if (state !== 2'd0 || wd_enable !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got state %0d en %b exp 0 0", state, wd_enable);
        end
    endtask

    task automatic test_grace();
        src_mask = 4'b0011;
        arm = 1'b1;
        push_hb(0);
        tick();
        arm = 1'b0;
        src_mask = 4'b1111;
        for (int i = 0; i < GRACE; i++) begin
            tests++;
            if (state !== 2'd1 || wd_enable !== 1'b1) begin
                fails++;
                $display("FAIL grace_dwell[%0d] got state %0d en %b exp 1 1", i, state, wd_enable);
            end
            src_kick = 4'b0011;
            tick();
        end
        src_kick = '0;
        tests++;
        if (state !== 2'd2 || wd_enable !== 1'b1) begin
            fails++;
            $display("FAIL armed_entry got state %0d en %b exp 2 1", state, wd_enable);
        end
    endtask

    task automatic test_kicks();
        src_kick = 4'b0001; tick();
        src_kick = '0;      tick(); tick();
        src_kick = 4'b0010; push_hb(1); tick();
        src_kick = '0;      tick();
        tests++;
        if (round_cnt !== 16'd1) begin
            fails++;
            $display("FAIL round_one got %0d exp 1", round_cnt);
        end
        src_kick = 4'b0001; tick();
        src_kick = '0;      tick();
        src_kick = 4'b0001; tick();
        src_kick = 4'b0100; tick();
        src_kick = '0;      tick(); tick();
        tests++;
        if (round_cnt !== 16'd1) begin
            fails++;
            $display("FAIL no_hb_partial got %0d exp 1", round_cnt);
        end
    endtask

    task automatic test_back_to_back();
        src_kick = 4'b0011; push_hb(2); tick();
        src_kick = 4'b0011; push_hb(3); tick();
        src_kick = '0;      tick();
        tests++;
        if (round_cnt !== 16'd3) begin
            fails++;
            $display("FAIL back_to_back got %0d exp 3", round_cnt);
        end
    endtask

    task automatic test_warning();
        src_kick = 4'b0001; tick();
        src_kick = '0; wd_warning = 1'b1; tick();
        tests++;
        if (missing !== 4'b0010) begin
            fails++;
            $display("FAIL missing got %b exp 0010", missing);
        end
        wd_triggered = 1'b1; tick();
        wd_triggered = 1'b0;
        tests++;
        if (state !== 2'd3 || fault !== 1'b1 || wd_enable !== 1'b1) begin
            fails++;
            $display("FAIL tripped got state %0d fault %b en %b exp 3 1 1", state, fault, wd_enable);
        end
        src_kick = 4'b0011; disarm = 1'b1; force_req = 1'b1; tick();
        src_kick = '0; disarm = 1'b0; force_req = 1'b0; tick();
        tests++;
        if (state !== 2'd3 || missing !== 4'b0010) begin
            fails++;
            $display("FAIL trip_hold got state %0d missing %b exp 3 0010", state, missing);
        end
        clear = 1'b1; tick();
        clear = 1'b0; wd_warning = 1'b0;
        tests++;
        if (state !== 2'd0 || fault !== 1'b0 || missing !== '0 || wd_enable !== 1'b0) begin
            fails++;
            $display("FAIL clear got state %0d fault %b missing %b en %b exp 0 0 0 0",
                     state, fault, missing, wd_enable);
        end
    endtask

    task automatic test_priority();
        arm_to_armed(4'b0011);
        wd_triggered = 1'b1; disarm = 1'b1; tick();
        wd_triggered = 1'b0; disarm = 1'b0;
        tests++;
        if (state !== 2'd3) begin
            fails++;
            $display("FAIL trig_over_disarm got state %0d exp 3", state);
        end
        clear = 1'b1; tick();
        clear = 1'b0;
        src_mask = 4'b0011; arm = 1'b1; disarm = 1'b1; tick();
        arm = 1'b0; disarm = 1'b0; tick();
        tests++;
        if (state !== 2'd0 || wd_enable !== 1'b0) begin
            fails++;
            $display("FAIL arm_disarm got state %0d en %b exp 0 0", state, wd_enable);
        end
        src_mask = '0; arm = 1'b1; tick(); tick();
        arm = 1'b0;
        tests++;
        if (state !== 2'd0) begin
            fails++;
            $display("FAIL arm_mask0 got state %0d exp 0", state);
        end
        arm_to_armed(4'b0011);
        disarm = 1'b1; tick();
        disarm = 1'b0;
        tests++;
        if (state !== 2'd0 || wd_enable !== 1'b0) begin
            fails++;
            $display("FAIL disarm got state %0d en %b exp 0 0", state, wd_enable);
        end
    endtask

    task automatic test_force();
        arm_to_armed(4'b0001);
        force_req = 1'b1;
        fr_q.push_back(cyc + 1);
        repeat (5) tick();
        force_req = 1'b0;
        tick(); tick();
        disarm = 1'b1; tick();
        disarm = 1'b0;
        force_req = 1'b1; repeat (3) tick();
        force_req = 1'b0; tick();
        tests++;
        if (fr_q.size() != 0) begin
            fails++;
            $display("FAIL force_pulse got %0d pending exp 0", fr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        src_mask = 4'b0011; arm = 1'b1; push_hb(0); tick();
        arm = 1'b0; tick(); tick();
        tests++;
        if (state !== 2'd1) begin
            fails++;
            $display("FAIL mid_grace got state %0d exp 1", state);
        end
        #1 rstn = 1'b0;
        #1;
        tests++;
        if ({state, wd_enable, wd_heartbeat, wd_force_reset, missing, fault, round_cnt} !== '0) begin
            fails++;
            $display("FAIL rst_grace got state %0d en %b exp 0 0", state, wd_enable);
        end
        tick(); rstn = 1'b1; tick();
        arm_to_armed(4'b0011);
        src_kick = 4'b0011; push_hb(1); tick();
        src_kick = '0;
        wd_triggered = 1'b1; tick();
        wd_triggered = 1'b0;
        tests++;
        if (state !== 2'd3 || round_cnt !== 16'd1) begin
            fails++;
            $display("FAIL pre_rst_trip got state %0d cnt %0d exp 3 1", state, round_cnt);
        end
        #1 rstn = 1'b0;
        #1;
        tests++;
        if ({state, wd_enable, wd_heartbeat, wd_force_reset, missing, fault, round_cnt} !== '0) begin
            fails++;
            $display("FAIL rst_trip got state %0d fault %b cnt %0d exp 0 0 0", state, fault, round_cnt);
        end
        tick(); rstn = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_grace();
        test_kicks();
        test_back_to_back();
        test_warning();
        test_priority();
        test_force();
        test_reset_mid();
        repeat (3) tick();
        tests++;
        if (hb_q.size() != 0) begin
            fails++;
            $display("FAIL hb_outstanding got %0d exp 0", hb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout got no finish exp finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
